scr1_ahb_imem_slave: RTL and testbench
======================================

# scr1_ahb_imem_slave

AHB-Lite read-only slave serving instruction fetches from a single-port synchronous SRAM (ROM/TCM image). It is the responder for the core's IMEM AHB bridge and sits on the instruction bus between the interconnect and a 1-cycle-latency memory macro. Wait states are programmable for timing studies. Unsupported accesses (writes, non-word size, misaligned, out-of-range) receive the standard two-cycle AHB ERROR response.

## Interface
- SCR1_AHB_WIDTH, 32 (from scr1_ahb.svh): data/address width.
- MEM_DEPTH, 4096: memory size in 32-bit words; AW = $clog2(MEM_DEPTH).
- WAIT_STATES, 0: extra data-phase cycles per read, range 0..7; CW = $clog2(WAIT_STATES+1), minimum 1.
- BASE_ADDR, 32'h0000_0000: byte base address; must be MEM_DEPTH*4 aligned.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- hsel  in  1  slave select.
- htrans  in  2  transfer type.
- haddr  in  32  byte address.
- hwrite  in  1  write flag.
- hsize  in  3  transfer size.
- hprot, hburst  in  4, 3  ignored.
- hready  in  1  bus-level ready (address-phase qualifier).
- hreadyout  out  1  slave ready.
- hrdata  out  32  read data.
- hresp  out  1  OKAY(0)/ERROR(1).
- mem_req  out  1  SRAM read strobe.
- mem_addr  out  AW  SRAM word address.
- mem_rdata  in  32  SRAM data, valid the cycle after mem_req.

## Operation
- Accept = hsel & htrans[1] & hready. NONSEQ and SEQ are handled identically; IDLE/BUSY produce no access and a zero-wait OKAY.
- Legal = ~hwrite & (hsize == SCR1_HSIZE_32B) & (haddr[1:0] == 0) & (haddr − BASE_ADDR) < MEM_DEPTH*4 (unsigned, 32-bit).
- mem_req = accept & legal, combinational; mem_addr = (haddr − BASE_ADDR)[AW+1:2].
- States: IDLE, RD, ERR1, ERR2.
  - IDLE: hreadyout=1, hresp=OKAY, hrdata=0. Accept & legal → RD with cnt=WAIT_STATES. Accept & ~legal → ERR1.
  - RD: hreadyout = (cnt==0); cnt decrements while nonzero. At cnt==0: hresp=OKAY, hrdata = (WAIT_STATES==0) ? mem_rdata : rdata_r. Next state follows the IDLE accept rules, or returns to IDLE if there is no accept.
  - ERR1: hreadyout=0, hresp=ERROR → ERR2.
  - ERR2: hreadyout=1, hresp=ERROR. Accept rules as IDLE; the master may cancel by driving IDLE.
- rdata_r captures mem_rdata on the first RD cycle (used when WAIT_STATES>0).
- Back-to-back: a new address phase is accepted in the completing cycle of the previous data phase. The new SRAM read overlaps the previous data output.
- hready low from another slave's data phase: no accept, state unchanged in IDLE.
- Reset mid-transfer: asynchronously returns to IDLE. The pending data phase is dropped.

## Timing
- Reset values: hreadyout=1, hresp=OKAY, hrdata=0, mem_req=0 (with hsel=0), state=IDLE, cnt=0, rdata_r=0.
- Read latency: data phase takes 1+WAIT_STATES cycles. With WAIT_STATES=0, sustained throughput is one word per cycle.
- Error: exactly 2 data-phase cycles (0/ERROR, then 1/ERROR), independent of WAIT_STATES.
- hrdata is undefined to the master except in a completing RD cycle. The block drives it to 0 in IDLE/ERR states.

## Structure
- HTRANS/HRESP/HSIZE constants come from scr1_ahb.svh. Add SCR1_HTRANS_SEQ there if it is missing.
- The FSM enum (type_scr1_ahb_slv_fsm_e) is local to the module.
- No sub-module. The SRAM is instantiated by the parent (scr1_top_ahb / testbench memory).
- Simulation assertions (SCR1_SIM_ENV):
  - no X on hsel/htrans/hready;
  - hreadyout=0 never lasts more than WAIT_STATES consecutive cycles in RD;
  - ERR1 is always followed by ERR2.

## Test plan
- WAIT_STATES=0, SRAM word 5 = 32'hDEADBEEF, single NONSEQ read at 0x14 → mem_req/mem_addr=5 in the address cycle. The next cycle gives hreadyout=1, hrdata=DEADBEEF, hresp=OKAY.
- WAIT_STATES=0, NONSEQ reads 0x0,0x4,0x8 on consecutive cycles → three consecutive completing cycles with words 0,1,2 and no hreadyout low.
- WAIT_STATES=3, read 0x8 → hreadyout=0 for 3 cycles, then 1 with word 2. A second transfer presented during the waits is not accepted until hreadyout=1.
- Write to 0x0, hsize=16-bit read at 0x4, and read at 0x2 → each gives hreadyout 0/ERROR then 1/ERROR, with mem_req never asserted.
- MEM_DEPTH=16, read at 0x40 → ERROR. Read at 0x3C → OKAY with word 15.
- Assert rst_n during cycle 2 of a WAIT_STATES=3 read → hreadyout=1/OKAY immediately. A following read at 0x0 completes normally.

Source files
------------

// File: rtl/scr1_ahb_imem_slave_pkg.sv
// Shared AHB-Lite encodings and helpers for the IMEM AHB slave.
package scr1_ahb_imem_slave_pkg;

  localparam int unsigned SCR1_AHB_WIDTH = 32;

  localparam logic [1:0] SCR1_HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] SCR1_HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] SCR1_HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] SCR1_HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] SCR1_HSIZE_8B  = 3'b000;
  localparam logic [2:0] SCR1_HSIZE_16B = 3'b001;
  localparam logic [2:0] SCR1_HSIZE_32B = 3'b010;

  localparam logic SCR1_HRESP_OKAY  = 1'b0;
  localparam logic SCR1_HRESP_ERROR = 1'b1;

  // Width of the wait-state down-counter; never narrower than one bit.
  function automatic int unsigned scr1_cnt_width(input int unsigned ws);
    return (ws == 0) ? 1 : $clog2(ws + 1);
  endfunction

endpackage

// File: rtl/scr1_ahb_imem_slave.sv
// AHB-Lite read-only slave in front of a 1-cycle-latency instruction SRAM.
// Reads complete after 1+WAIT_STATES data-phase cycles; unsupported accesses
// get the two-cycle ERROR response.
module scr1_ahb_imem_slave
  import scr1_ahb_imem_slave_pkg::*;
#(
  parameter int unsigned                    MEM_DEPTH   = 4096,
  parameter int unsigned                    WAIT_STATES = 0,
  parameter logic [SCR1_AHB_WIDTH-1:0]      BASE_ADDR   = '0,
  localparam int unsigned                   AW          = $clog2(MEM_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      hsel,
  input  logic [1:0]                htrans,
  input  logic [SCR1_AHB_WIDTH-1:0] haddr,
  input  logic                      hwrite,
  input  logic [2:0]                hsize,
  input  logic [3:0]                hprot,
  input  logic [2:0]                hburst,
  input  logic                      hready,
  output logic                      hreadyout,
  output logic [SCR1_AHB_WIDTH-1:0] hrdata,
  output logic                      hresp,
  output logic                      mem_req,
  output logic [AW-1:0]             mem_addr,
  input  logic [SCR1_AHB_WIDTH-1:0] mem_rdata
);

  localparam int unsigned CW = scr1_cnt_width(WAIT_STATES);
  localparam logic [SCR1_AHB_WIDTH:0] MEM_BYTES =
    (SCR1_AHB_WIDTH + 1)'(MEM_DEPTH) << 2;

  typedef enum logic [1:0] {
    SLV_IDLE,
    SLV_RD,
    SLV_ERR1,
    SLV_ERR2
  } type_scr1_ahb_slv_fsm_e;

  type_scr1_ahb_slv_fsm_e      r_state;
  logic [CW-1:0]               r_cnt;
  logic [SCR1_AHB_WIDTH-1:0]   r_rdata;
  logic                        r_hreadyout;
  logic                        r_hresp;
  logic                        r_done;

  type_scr1_ahb_slv_fsm_e      w_next_state;
  logic [CW-1:0]               w_next_cnt;
  logic                        w_next_ready;
  logic                        w_next_resp;
  logic                        w_next_done;
  logic                        w_accept;
  logic                        w_legal;
  logic                        w_take_new;
  logic [SCR1_AHB_WIDTH-1:0]   w_offset;
  logic                        w_unused_bits;

  assign w_offset = haddr - BASE_ADDR;
  assign w_accept = hsel & htrans[1] & hready;
  assign w_legal  = ~hwrite
                  & (hsize == SCR1_HSIZE_32B)
                  & (haddr[1:0] == 2'b00)
                  & ({1'b0, w_offset} < MEM_BYTES);

  assign mem_req  = w_accept & w_legal;
  assign mem_addr = w_offset[AW+1:2];

  assign w_unused_bits = ^{hprot, hburst, w_offset[1:0],
                           w_offset[SCR1_AHB_WIDTH-1:AW+2]};

  // Next-state decode; a new address phase is only taken when the current
  // data phase is completing (or none is in flight).
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_take_new   = (r_state == SLV_IDLE) || (r_state == SLV_ERR2) ||
                   ((r_state == SLV_RD) && (r_cnt == '0));
    if (r_state == SLV_ERR1) begin
      w_next_state = SLV_ERR2;
    end else if (w_take_new) begin
      if (w_accept && w_legal) begin
        w_next_state = SLV_RD;
        w_next_cnt   = CW'(WAIT_STATES);
      end else if (w_accept) begin
        w_next_state = SLV_ERR1;
      end else begin
        w_next_state = SLV_IDLE;
      end
    end else begin
      w_next_cnt = r_cnt - CW'(1);
    end
    // Bus outputs are registered, so decode them from the upcoming state.
    w_next_ready = (w_next_state == SLV_RD) ? (w_next_cnt == '0)
                                            : (w_next_state != SLV_ERR1);
    w_next_resp  = (w_next_state == SLV_ERR1) || (w_next_state == SLV_ERR2);
    w_next_done  = (w_next_state == SLV_RD) && (w_next_cnt == '0);
  end

  // FSM state, wait counter, registered bus outputs and read-data capture.
  always_ff @(posedge clk, negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= SLV_IDLE;
      r_cnt       <= '0;
      r_rdata     <= '0;
      r_hreadyout <= 1'b1;
      r_hresp     <= SCR1_HRESP_OKAY;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_cnt       <= w_next_cnt;
      r_hreadyout <= w_next_ready;
      r_hresp     <= w_next_resp;
      r_done      <= w_next_done;
      if ((r_state == SLV_RD) && (r_cnt == CW'(WAIT_STATES))) begin
        r_rdata <= mem_rdata;
      end
    end
  end

  assign hreadyout = r_hreadyout;
  assign hresp     = r_hresp;
  assign hrdata    = r_done ? ((WAIT_STATES == 0) ? mem_rdata : r_rdata) : '0;

`ifdef SCR1_SIM_ENV
  logic [3:0] r_sim_wait;
  logic       r_sim_err1;

  // Track consecutive wait cycles in RD and the previous ERR1 state.
  always_ff @(posedge clk, negedge rst_n) begin
    if (!rst_n) begin
      r_sim_wait <= '0;
      r_sim_err1 <= 1'b0;
    end else begin
      r_sim_wait <= ((r_state == SLV_RD) && !r_hreadyout) ? r_sim_wait + 4'd1 : '0;
      r_sim_err1 <= (r_state == SLV_ERR1);
    end
  end

  // Protocol sanity checks on inputs and FSM sequencing.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!$isunknown({hsel, htrans, hready}));
      assert (r_sim_wait <= 4'(WAIT_STATES));
      assert (!r_sim_err1 || (r_state == SLV_ERR2));
    end
  end
`endif

endmodule

// File: tb/tb_scr1_ahb_imem_slave.sv
// Bench for scr1_ahb_imem_slave: two instances (0 and 3 wait states, the
// second at a non-zero base), table vectors, corner sequences, random traffic.
module tb_scr1_ahb_imem_slave;
  import scr1_ahb_imem_slave_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] BASE1 = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hsel[2];
  logic [1:0]  htrans[2];
  logic [31:0] haddr[2];
  logic        hwrite[2];
  logic [2:0]  hsize[2];
  logic [3:0]  hprot[2];
  logic [2:0]  hburst[2];
  logic        hready[2];
  logic        hreadyout[2];
  logic [31:0] hrdata[2];
  logic        hresp[2];
  logic        mem_req[2];
  logic [3:0]  mem_addr[2];
  logic [31:0] mem_rdata[2];
  logic [31:0] mem[2][DEPTH];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  scr1_ahb_imem_slave #(.MEM_DEPTH(DEPTH), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .hsel(hsel[0]), .htrans(htrans[0]), .haddr(haddr[0]),
    .hwrite(hwrite[0]), .hsize(hsize[0]), .hprot(hprot[0]), .hburst(hburst[0]),
    .hready(hready[0]), .hreadyout(hreadyout[0]), .hrdata(hrdata[0]), .hresp(hresp[0]),
    .mem_req(mem_req[0]), .mem_addr(mem_addr[0]), .mem_rdata(mem_rdata[0]));

  scr1_ahb_imem_slave #(.MEM_DEPTH(DEPTH), .WAIT_STATES(3), .BASE_ADDR(BASE1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .hsel(hsel[1]), .htrans(htrans[1]), .haddr(haddr[1]),
    .hwrite(hwrite[1]), .hsize(hsize[1]), .hprot(hprot[1]), .hburst(hburst[1]),
    .hready(hready[1]), .hreadyout(hreadyout[1]), .hrdata(hrdata[1]), .hresp(hresp[1]),
    .mem_req(mem_req[1]), .mem_addr(mem_addr[1]), .mem_rdata(mem_rdata[1]));

  // Synchronous SRAMs, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_req[0]) mem_rdata[0] <= mem[0][mem_addr[0]];
    if (mem_req[1]) mem_rdata[1] <= mem[1][mem_addr[1]];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        ready;
    logic        resp;
    logic        chk;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    int          d;
    logic [1:0]  tr;
    logic [31:0] a;
    logic        wr;
    logic [2:0]  sz;
    logic        exp_req;
    logic [3:0]  exp_maddr;
    logic        exp_err;
    logic [31:0] exp_word;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[$];

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic logic [31:0] base_of(input int d);
    return (d == 0) ? 32'h0 : BASE1;
  endfunction

  function automatic logic model_legal(input int d, input logic [31:0] a,
                                       input logic wr, input logic [2:0] sz);
    logic [31:0] b;
    b = base_of(d);
    return !wr && (sz == 3'd2) && (a[1:0] == 2'b00) && (a >= b) && (a < b + DEPTH * 4);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic push_read(input int d, input logic [31:0] word);
    for (int i = 0; i < ws_of(d); i++) exp_q.push_back('{1'b0, 1'b0, 1'b0, 32'h0});
    exp_q.push_back('{1'b1, 1'b0, 1'b1, word});
  endtask

  task automatic push_err();
    exp_q.push_back('{1'b0, 1'b1, 1'b1, 32'h0});
    exp_q.push_back('{1'b1, 1'b1, 1'b1, 32'h0});
  endtask

  // One bus cycle, entered just after a falling edge: check the current data
  // phase, drive the next address phase, check the SRAM strobe, advance.
  task automatic cycle(input int d, input logic sel, input logic [1:0] tr,
                       input logic [31:0] a, input logic wr, input logic [2:0] sz,
                       input logic stall, input logic use_model,
                       input logic t_req, input logic [3:0] t_maddr);
    exp_t cur;
    logic acc, leg, ereq;
    logic [3:0] eaddr;
    cur = '{1'b1, 1'b0, 1'b1, 32'h0};
    if (exp_q.size() > 0) cur = exp_q.pop_front();
    chk("hreadyout", 32'(hreadyout[d]), 32'(cur.ready));
    chk("hresp", 32'(hresp[d]), 32'(cur.resp));
    if (cur.chk) chk("hrdata", hrdata[d], cur.data);
    hsel[d] = sel; htrans[d] = tr; haddr[d] = a; hwrite[d] = wr; hsize[d] = sz;
    hprot[d] = 4'($urandom); hburst[d] = 3'($urandom);
    hready[d] = stall ? 1'b0 : cur.ready;
    #1;
    acc = sel && tr[1] && !stall && cur.ready;
    leg = model_legal(d, a, wr, sz);
    if (use_model) begin
      ereq  = acc && leg;
      eaddr = 4'((a - base_of(d)) >> 2);
    end else begin
      ereq  = t_req;
      eaddr = t_maddr;
    end
    chk("mem_req", 32'(mem_req[d]), 32'(ereq));
    if (ereq) chk("mem_addr", 32'(mem_addr[d]), 32'(eaddr));
    if (use_model && acc) begin
      if (leg) push_read(d, mem[d][eaddr]);
      else push_err();
    end
    @(negedge clk);
  endtask

  task automatic idle(input int d);
    cycle(d, 1'b0, SCR1_HTRANS_IDLE, 32'h0, 1'b0, SCR1_HSIZE_32B, 1'b0, 1'b1, 1'b0, 4'h0);
  endtask

  task automatic drain(input int d);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) idle(d);
    idle(d);
  endtask

  task automatic rd(input int d, input logic [31:0] a);
    cycle(d, 1'b1, SCR1_HTRANS_NONSEQ, a, 1'b0, SCR1_HSIZE_32B, 1'b0, 1'b1, 1'b0, 4'h0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      hsel[d] = 1'b0; htrans[d] = SCR1_HTRANS_IDLE; haddr[d] = '0; hwrite[d] = 1'b0;
      hsize[d] = SCR1_HSIZE_32B; hprot[d] = '0; hburst[d] = '0; hready[d] = 1'b1;
      for (int i = 0; i < int'(DEPTH); i++)
        mem[d][i] = 32'h1000_0000 * (d + 1) + i * 32'h0001_0001;
    end
    mem[0][5] = 32'hDEAD_BEEF;

    tbl.push_back('{0, SCR1_HTRANS_NONSEQ, 32'h14,   1'b0, SCR1_HSIZE_32B, 1'b1, 4'd5,  1'b0, 32'hDEAD_BEEF});
    tbl.push_back('{0, SCR1_HTRANS_SEQ,    32'h3C,   1'b0, SCR1_HSIZE_32B, 1'b1, 4'd15, 1'b0, 32'h100F_000F});
    tbl.push_back('{0, SCR1_HTRANS_NONSEQ, 32'h40,   1'b0, SCR1_HSIZE_32B, 1'b0, 4'd0,  1'b1, 32'h0});
    tbl.push_back('{0, SCR1_HTRANS_NONSEQ, 32'h0,    1'b1, SCR1_HSIZE_32B, 1'b0, 4'd0,  1'b1, 32'h0});
    tbl.push_back('{0, SCR1_HTRANS_NONSEQ, 32'h4,    1'b0, SCR1_HSIZE_16B, 1'b0, 4'd0,  1'b1, 32'h0});
    tbl.push_back('{0, SCR1_HTRANS_NONSEQ, 32'h2,    1'b0, SCR1_HSIZE_32B, 1'b0, 4'd0,  1'b1, 32'h0});
    tbl.push_back('{0, SCR1_HTRANS_IDLE,   32'h8,    1'b0, SCR1_HSIZE_32B, 1'b0, 4'd0,  1'b0, 32'h0});
    tbl.push_back('{0, SCR1_HTRANS_BUSY,   32'h8,    1'b0, SCR1_HSIZE_32B, 1'b0, 4'd0,  1'b0, 32'h0});
    tbl.push_back('{1, SCR1_HTRANS_NONSEQ, 32'h1008, 1'b0, SCR1_HSIZE_32B, 1'b1, 4'd2,  1'b0, 32'h2002_0002});
    tbl.push_back('{1, SCR1_HTRANS_NONSEQ, 32'h0,    1'b0, SCR1_HSIZE_32B, 1'b0, 4'd0,  1'b1, 32'h0});
    tbl.push_back('{1, SCR1_HTRANS_NONSEQ, 32'h1040, 1'b0, SCR1_HSIZE_32B, 1'b0, 4'd0,  1'b1, 32'h0});
    tbl.push_back('{1, SCR1_HTRANS_NONSEQ, 32'h103C, 1'b0, SCR1_HSIZE_32B, 1'b1, 4'd15, 1'b0, 32'h200F_000F});
    tbl.push_back('{1, SCR1_HTRANS_NONSEQ, 32'h1004, 1'b1, SCR1_HSIZE_32B, 1'b0, 4'd0,  1'b1, 32'h0});
    tbl.push_back('{1, SCR1_HTRANS_SEQ,    32'h1000, 1'b0, SCR1_HSIZE_32B, 1'b1, 4'd0,  1'b0, 32'h2000_0000});

    // Reset state.
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst hreadyout", 32'(hreadyout[d]), 32'h1);
      chk("rst hresp", 32'(hresp[d]), 32'h0);
      chk("rst hrdata", hrdata[d], 32'h0);
      chk("rst mem_req", 32'(mem_req[d]), 32'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors: single transfers with fixed expected responses.
    foreach (tbl[k]) begin
      cycle(tbl[k].d, 1'b1, tbl[k].tr, tbl[k].a, tbl[k].wr, tbl[k].sz,
            1'b0, 1'b0, tbl[k].exp_req, tbl[k].exp_maddr);
      if (tbl[k].exp_err) push_err();
      else if (tbl[k].exp_req) push_read(tbl[k].d, tbl[k].exp_word);
      drain(tbl[k].d);
    end

    // Back-to-back zero-wait reads.
    rd(0, 32'h0); rd(0, 32'h4); rd(0, 32'h8);
    drain(0);

    // Wait-state read with a second transfer held during the waits.
    rd(1, BASE1 + 32'h8);
    repeat (4) rd(1, BASE1 + 32'hC);
    drain(1);

    // Another slave's data phase holds hready low: no access.
    cycle(0, 1'b1, SCR1_HTRANS_NONSEQ, 32'h4, 1'b0, SCR1_HSIZE_32B, 1'b1, 1'b1, 1'b0, 4'h0);
    drain(0);

    // Reset in the second data cycle of a wait-state read.
    rd(1, BASE1 + 32'h4);
    idle(1);
    rst_n = 1'b0;
    #1;
    chk("midrst hreadyout", 32'(hreadyout[1]), 32'h1);
    chk("midrst hresp", 32'(hresp[1]), 32'h0);
    chk("midrst hrdata", hrdata[1], 32'h0);
    chk("midrst mem_req", 32'(mem_req[1]), 32'h0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    rd(1, BASE1);
    drain(1);

    // Random traffic against the reference model.
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 700; n++) begin
        logic        sel, wr, stall;
        logic [1:0]  tr;
        logic [2:0]  sz;
        logic [31:0] a;
        int unsigned r;
        sel = ($urandom % 5) != 0;
        tr  = 2'($urandom);
        r   = $urandom % 8;
        if (r < 5)       a = base_of(d) + 4 * $urandom_range(0, DEPTH - 1);
        else if (r == 5) a = base_of(d) + $urandom_range(0, DEPTH * 4 + 16);
        else if (r == 6) a = $urandom;
        else             a = base_of(d) + DEPTH * 4 + 4 * ($urandom % 4);
        wr    = ($urandom % 8) == 0;
        sz    = (($urandom % 6) == 0) ? 3'($urandom % 3) : SCR1_HSIZE_32B;
        stall = (exp_q.size() == 0) && (($urandom % 10) == 0);
        cycle(d, sel, tr, a, wr, sz, stall, 1'b1, 1'b0, 4'h0);
      end
      drain(d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
